// File: rtl/tx_link_ctrl.sv
// tx_link_ctrl: reads a frame from the TX buffer and streams it byte-wise to the 4B5B encoder.
// Latency: first byte presented 2 cycles after tx_start; payload one byte per 2 cycles, CRC bytes back-to-back.
// Backpressure: enc_rdy low stalls the block indefinitely with every output held stable.
// Optional CRC-32 trailer: define TX_LINK_CRC_APPEND_EN.
module tx_link_ctrl #(
    parameter int n     = 11,
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [n-1:0]     tx_len,
    output logic             tx_buf_rden,
    output logic [n-1:0]     tx_buf_raddr,
    input  logic [width-1:0] tx_buf_rdata,
    output logic             enc_en,
    output logic [width-1:0] enc_data,
    output logic             enc_vld,
    input  logic             enc_rdy,
    output logic             tx_busy,
    output logic             tx_done
);

`ifdef TX_LINK_CRC_APPEND_EN
    typedef enum logic [2:0] {IDLE, FETCH, DATA, CRC, END} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, DATA, END} state_t;
`endif

    localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [n-1:0]     len_q;
    logic [n-1:0]     addr_q;
    logic [n-1:0]     issue_addr;
    logic [width-1:0] data_q;
    logic             vld_q;
    logic             rden_c;
    logic             xfer;
    logic             start_ok;
    logic             last_byte;

    assign xfer      = vld_q & enc_rdy;
    assign start_ok  = tx_start & (tx_len != '0);
    // addr_q always holds the index of the byte currently presented
    assign last_byte = (addr_q == (len_q - ONE));

`ifdef TX_LINK_CRC_APPEND_EN
    logic [31:0] crc_q;
    logic [31:0] crc_upd;
    logic [31:0] crc_fin;
    logic [1:0]  crc_cnt_q;

    // Reflected CRC-32 update, one data bit per iteration, LSB first
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [width-1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < width; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign crc_upd = crc_step(crc_q, data_q);
    assign crc_fin = ~crc_upd;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and buffer read issue
    always_comb begin
        state_d    = state_q;
        rden_c     = 1'b0;
        issue_addr = '0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    rden_c  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = DATA;
            DATA: begin
                if (xfer) begin
                    if (!last_byte) begin
                        rden_c     = 1'b1;
                        issue_addr = addr_q + ONE;
                        state_d    = FETCH;
                    end else begin
`ifdef TX_LINK_CRC_APPEND_EN
                        state_d = CRC;
`else
                        state_d = END;
`endif
                    end
                end
            end
`ifdef TX_LINK_CRC_APPEND_EN
            CRC: begin
                if (xfer && (crc_cnt_q == 2'd3)) state_d = END;
            end
`endif
            END:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The read strobe is combinational so buffer data lands exactly in FETCH; reset masks it
    assign tx_buf_rden  = rden_c & ~rst;
    assign tx_buf_raddr = rden_c ? issue_addr : addr_q;
    assign tx_busy      = (state_q != IDLE) && (state_q != END);
    assign enc_en       = tx_busy;
    assign tx_done      = (state_q == END);
    assign enc_data     = data_q;
    assign enc_vld      = vld_q;

    // Length, address and output byte register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            if ((state_q == IDLE) && start_ok) len_q <= tx_len;
            if (rden_c) addr_q <= issue_addr;
            case (state_q)
                FETCH: begin
                    data_q <= tx_buf_rdata;
                    vld_q  <= 1'b1;
                end
                DATA: begin
                    if (xfer) begin
`ifdef TX_LINK_CRC_APPEND_EN
                        // Last payload byte: first CRC byte follows with no gap
                        if (last_byte) begin
                            data_q <= width'(crc_fin[7:0]);
                            vld_q  <= 1'b1;
                        end else begin
                            vld_q  <= 1'b0;
                        end
`else
                        vld_q <= 1'b0;
`endif
                    end
                end
`ifdef TX_LINK_CRC_APPEND_EN
                CRC: begin
                    if (xfer) begin
                        if (crc_cnt_q == 2'd3) vld_q  <= 1'b0;
                        else                   data_q <= width'(crc_q[7:0]);
                    end
                end
`endif
                END: begin
                    addr_q <= '0;
                    data_q <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef TX_LINK_CRC_APPEND_EN
    // CRC accumulator; after the payload it holds the remaining trailer bytes, shifted out LSB first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q     <= 32'hFFFFFFFF;
            crc_cnt_q <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        crc_q     <= 32'hFFFFFFFF;
                        crc_cnt_q <= 2'd0;
                    end
                end
                DATA: begin
                    if (xfer) crc_q <= last_byte ? (crc_fin >> 8) : crc_upd;
                end
                CRC: begin
                    if (xfer) begin
                        crc_q     <= crc_q >> 8;
                        crc_cnt_q <= crc_cnt_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Testbench for tx_link_ctrl: scoreboard of expected encoder bytes, read addresses and frame lengths.
// Stimulus drives at posedge+1; the monitor samples at negedge.
// Expected CRC trailer follows TX_LINK_CRC_APPEND_EN as compiled.
`timescale 1ns/1ps
module tb_tx_link_ctrl;
    localparam int N = 11;
    localparam int W = 8;
`ifdef TX_LINK_CRC_APPEND_EN
    localparam int CRC_BYTES = 4;
`else
    localparam int CRC_BYTES = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tx_start = 1'b0;
    logic [N-1:0] tx_len = '0;
    logic         tx_buf_rden;
    logic [N-1:0] tx_buf_raddr;
    logic [W-1:0] tx_buf_rdata = '0;
    logic         enc_en;
    logic [W-1:0] enc_data;
    logic         enc_vld;
    logic         enc_rdy = 1'b0;
    logic         tx_busy;
    logic         tx_done;

    tx_link_ctrl #(.n(N), .width(W)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_len(tx_len),
        .tx_buf_rden(tx_buf_rden), .tx_buf_raddr(tx_buf_raddr), .tx_buf_rdata(tx_buf_rdata),
        .enc_en(enc_en), .enc_data(enc_data), .enc_vld(enc_vld), .enc_rdy(enc_rdy),
        .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    logic [7:0]   mem [0:2047];
    logic [7:0]   exp_q [$];
    logic [N-1:0] addr_q [$];
    int           len_q [$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           last_xfer_cyc = -100;
    int           xfer_cnt = 0;
    int           rdy_mode = 0;
    bit           stall_prev = 1'b0;
    logic [7:0]   stall_data = '0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] all_outs();
        return {tx_buf_rden, tx_buf_raddr, enc_en, enc_data, enc_vld, tx_busy, tx_done};
    endfunction

    // Reference CRC-32 (reflected, init and final XOR all ones) over mem[0..len-1]
    function automatic logic [31:0] ref_crc(input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'h0, mem[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push_frame(input int len);
        logic [31:0] crc;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(mem[i]);
            addr_q.push_back(i[N-1:0]);
        end
        if (CRC_BYTES != 0) begin
            crc = ref_crc(len);
            for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
        end
        len_q.push_back(len + CRC_BYTES);
    endtask

    task automatic pulse_start(input int len);
        @(posedge clk); #1;
        tx_start = 1'b1;
        tx_len   = len[N-1:0];
        @(posedge clk); #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(k < budget, {name, "_timeout"}, k, budget);
        chk(addr_q.size() == 0, {name, "_reads_left"}, addr_q.size(), 0);
        exp_q.delete();
        addr_q.delete();
        len_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
    endtask

    // TX buffer: data valid one cycle after the read strobe
    initial begin
        forever begin
            @(posedge clk);
            if (tx_buf_rden) tx_buf_rdata <= mem[tx_buf_raddr];
        end
    end

    // Encoder ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = random
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       enc_rdy = 1'b1;
                1:       enc_rdy = ~enc_rdy;
                default: enc_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transfer, read issue and end-of-frame pulse
    initial begin
        logic [7:0]   e;
        logic [N-1:0] a;
        int           el;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    chk(enc_vld && (enc_data == stall_data), "hold_while_stalled",
                        {enc_vld, enc_data}, {1'b1, stall_data});
                if (enc_vld && enc_rdy) begin
                    chk(exp_q.size() != 0, "xfer_expected", 1, 0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk(enc_data == e, "enc_data", enc_data, e);
                    end
                    chk(enc_en && tx_busy, "envelope_during_xfer", {enc_en, tx_busy}, 2'b11);
                    last_xfer_cyc = cyc;
                    xfer_cnt++;
                end
                stall_prev = enc_vld && !enc_rdy;
                stall_data = enc_data;
                if (tx_buf_rden) begin
                    chk(addr_q.size() != 0, "read_expected", tx_buf_raddr, 0);
                    if (addr_q.size() != 0) begin
                        a = addr_q.pop_front();
                        chk(tx_buf_raddr == a, "read_addr", tx_buf_raddr, a);
                    end
                end
                if (tx_done) begin
                    chk(len_q.size() != 0, "done_expected", 1, 0);
                    if (len_q.size() != 0) begin
                        el = len_q.pop_front();
                        chk(xfer_cnt == el, "frame_bytes", xfer_cnt, el);
                    end
                    xfer_cnt = 0;
                    chk(!enc_en && !tx_busy, "envelope_at_done", {enc_en, tx_busy}, 0);
                    chk(cyc - last_xfer_cyc == 1, "done_latency", cyc - last_xfer_cyc, 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int len;
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);

        // Reset state, with a start request held during reset
        tx_start = 1'b1;
        tx_len   = 11'd5;
        repeat (3) @(negedge clk);
        chk(all_outs() == 24'h0, "reset_outputs", all_outs(), 0);
        @(posedge clk); #1;
        rst      = 1'b0;
        tx_start = 1'b0;
        repeat (3) @(negedge clk);
        chk(all_outs() == 24'h0, "idle_after_reset", all_outs(), 0);

        // "123456789" with literal expectations
        rdy_mode = 0;
        for (int i = 0; i < 9; i++) begin
            mem[i] = 8'h31 + 8'(i);
            exp_q.push_back(8'h31 + 8'(i));
            addr_q.push_back(i[N-1:0]);
        end
`ifdef TX_LINK_CRC_APPEND_EN
        exp_q.push_back(8'h26);
        exp_q.push_back(8'h39);
        exp_q.push_back(8'hF4);
        exp_q.push_back(8'hCB);
`endif
        len_q.push_back(9 + CRC_BYTES);
        pulse_start(9);
        wait_done(200, "check_string");

        // Single byte with encoder ready toggling
        rdy_mode = 1;
        mem[0] = 8'hA5;
        push_frame(1);
        pulse_start(1);
        wait_done(200, "len1_toggle");

        // Zero length request is ignored
        rdy_mode = 0;
        pulse_start(0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk(!tx_busy && !enc_en && !tx_buf_rden, "len0_ignored",
                {tx_busy, enc_en, tx_buf_rden}, 0);
        end

        // Reset after the second transfer of a 4-byte frame
        fill_random(4);
        push_frame(4);
        pulse_start(4);
        k = 0;
        while (exp_q.size() > 4 + CRC_BYTES - 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(k < 100, "rst_wait_timeout", k, 100);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk(all_outs() == 24'h0, "midframe_reset_outputs", all_outs(), 0);
        exp_q.delete();
        addr_q.delete();
        len_q.delete();
        xfer_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk(all_outs() == 24'h0, "reset_held_outputs", all_outs(), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        fill_random(2);
        push_frame(2);
        pulse_start(2);
        wait_done(200, "after_reset_len2");

        // Restart request mid-frame with a different length is ignored
        fill_random(5);
        push_frame(5);
        pulse_start(5);
        repeat (2) @(posedge clk);
        pulse_start(7);
        wait_done(300, "restart_ignored");

        // Back-to-back: new start in the cycle right after the end pulse
        fill_random(3);
        push_frame(3);
        push_frame(2);
        pulse_start(3);
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (tx_done) break;
        end
        chk(k < 200, "b2b_first_done", k, 200);
        pulse_start(2);
        wait_done(300, "back_to_back");

        // Random frames with random backpressure
        for (int f = 0; f < 8; f++) begin
            rdy_mode = $urandom_range(0, 2);
            len = $urandom_range(1, 24);
            fill_random(len);
            push_frame(len);
            pulse_start(len);
            wait_done(8 * (len + CRC_BYTES) + 100, "random_frame");
        end

        // Maximum length: addresses 0..2^n-2 with no wrap
        rdy_mode = 0;
        len = (1 << N) - 1;
        fill_random(len);
        push_frame(len);
        pulse_start(len);
        wait_done(3 * len + 100, "max_len");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_link_ctrl.md
TX_LINK_CTRL -- requirements
Module: tx_link_ctrl

Interface
REQ-001 The block SHALL have parameter n, default 11, meaning TX buffer address width and frame length width.
REQ-002 The block SHALL have parameter width, default 8, meaning data byte width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as the codebase does:
- clk  input  1: rising-edge clock.
- rst  input  1: asynchronous active-high reset.
REQ-004 The block SHALL have these further ports:
- tx_start  input  1: frame request, one-cycle pulse.
- tx_len  input  n: payload byte count, sampled with tx_start.
- tx_buf_rden  output  1: TX buffer read enable.
- tx_buf_raddr  output  n: TX buffer read address.
- tx_buf_rdata  input  width: buffer data, valid 1 cycle after rden.
- enc_en  output  1: frame envelope to the 4B5B encoder, high for the whole frame.
- enc_data  output  width: byte to the encoder.
- enc_vld  output  1: enc_data valid.
- enc_rdy  input  1: encoder accepts the byte.
- tx_busy  output  1: frame in progress.
- tx_done  output  1: one-cycle end-of-frame pulse.

Function
REQ-005 The FSM SHALL have the states IDLE, FETCH, DATA, CRC and END.
REQ-006 In IDLE, a tx_start with tx_len!=0 SHALL latch tx_len, assert tx_busy and enc_en, drive rden=1 with raddr=0, and move to FETCH.
REQ-007 A tx_start with tx_len==0 SHALL be ignored: no state change, no tx_done.
REQ-008 A tx_start while tx_busy=1 SHALL be ignored.
REQ-009 In FETCH, one cycle after rden, the block SHALL capture tx_buf_rdata into the output register, set enc_vld=1 and move to DATA.
REQ-010 A byte SHALL transfer on any cycle with enc_vld&&enc_rdy; enc_data and enc_vld SHALL hold stable until that transfer.
REQ-011 On a DATA transfer of byte i<len-1, the block SHALL issue rden with raddr=i+1 in the same cycle, drop enc_vld for exactly one cycle, then present byte i+1.
REQ-012 Payload throughput SHALL therefore be at most one byte per 2 cycles.
REQ-013 On the DATA transfer of byte len-1, the block SHALL go to CRC when CRC is compiled in, otherwise to END.
REQ-014 The CRC SHALL be CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, updated byte-wise on each payload transfer.
REQ-015 In CRC, the block SHALL send 4 bytes, least-significant byte first, with vld/rdy rules identical to DATA and no gap cycle between CRC bytes.
REQ-016 In END, the block SHALL pulse tx_done for 1 cycle, deassert enc_en and tx_busy in that same cycle, and return to IDLE.
REQ-017 tx_start on the cycle after END SHALL be accepted.
REQ-018 The address counter SHALL be n bits wide; a length of 2^n-1 SHALL read addresses 0..2^n-2 with no wrap.
REQ-019 tx_buf_rden SHALL be high only in the single cycle of each read issue.
REQ-020 enc_rdy held low SHALL stall the block indefinitely with all outputs stable.
REQ-021 enc_rdy while enc_vld=0 SHALL have no effect.

Reset
REQ-022 rst=1 SHALL force IDLE immediately, including mid-frame, and drive all outputs to 0.
REQ-023 A reset mid-frame SHALL abort the frame with no tx_done.
REQ-024 Reset SHALL set the CRC register to 0xFFFFFFFF and clear the length and address counters.

Configuration
REQ-025 With macro TX_LINK_CRC_APPEND_EN defined, the block SHALL append the 4 CRC bytes after the payload (frame = len+4 bytes).
REQ-026 Without TX_LINK_CRC_APPEND_EN, the CRC logic and CRC state SHALL be compiled out and DATA SHALL go directly to END (frame = len bytes).

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Buffer "123456789" (0x31..0x39), len=9, enc_rdy=1, EN defined -> 13 bytes 0x31..0x39,0x26,0x39,0xF4,0xCB; one tx_done; enc_en high throughout.
- Same stimulus with EN undefined -> 9 bytes, tx_done 1 cycle after the 9th transfer.
- len=1, byte 0xA5, enc_rdy toggling 1/0 every cycle -> no byte lost or duplicated; enc_data stable while vld&&!rdy.
- tx_start with len=0 -> tx_busy, enc_en, rden stay 0; no tx_done.
- len=4, rst asserted after the 2nd transfer -> all outputs 0 next edge; no tx_done; a new len=2 frame then sends buffer bytes 0,1 correctly.
- tx_start re-pulsed mid-frame with len=7 -> ignored; the original frame length is kept.
